// File: rtl/pixel_stream_pkg.sv
// Shared types and default geometry for the pixel frame writer.
// Channel layout is {r, g, b}, most significant channel first.
package pixel_stream_pkg;

    localparam int unsigned WIDTH_DEF       = 640;
    localparam int unsigned HEIGHT_DEF      = 480;
    localparam int unsigned INDEX_WIDTH_DEF = 19;
    localparam int unsigned PIXEL_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain,
        StDone
    } state_t;

    typedef struct packed {
        logic [PIXEL_DEPTH_DEF-1:0] r;
        logic [PIXEL_DEPTH_DEF-1:0] g;
        logic [PIXEL_DEPTH_DEF-1:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Frame-buffer write bus: the writer is the master, the buffer answers with ready.
interface pixel_frame_writer_if
    import pixel_stream_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int unsigned PIXEL_DEPTH = PIXEL_DEPTH_DEF
);

    logic                     mem_wr_en;
    logic [INDEX_WIDTH-1:0]   mem_wr_addr;
    logic [3*PIXEL_DEPTH-1:0] mem_wr_data;
    logic                     mem_wr_ready;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_ready
    );

    modport slave (
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_ready
    );

endinterface

// File: rtl/pixel_wr_fifo.sv
// Small write queue; head entry is read straight from storage so it holds while stalled.
// DEPTH must be a power of two, at least 2.
module pixel_wr_fifo #(
    parameter int unsigned DATA_WIDTH = 43,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CntW      = $clog2(DEPTH) + 1,
    localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [CntW-1:0]       count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  do_push;
    logic                  do_pop;

    // Full is taken from the registered count: a pop in the same cycle does not make room.
    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Captures one frame of strobed pixels into a linear frame buffer through a write queue.
// Optional PIXEL_CHECKSUM_EN adds checksum_o, the 16-bit sum of R+G+B over the frame.
module pixel_frame_writer
    import pixel_stream_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned HEIGHT      = HEIGHT_DEF,
    parameter int unsigned PIXEL_DEPTH = PIXEL_DEPTH_DEF,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     valid_i,
    input  logic [3*PIXEL_DEPTH-1:0] pix_i,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow,
    output logic [12:0]              row_o,
    output logic [12:0]              col_o,
    pixel_frame_writer_if.master     mem
`ifdef PIXEL_CHECKSUM_EN
    ,
    output logic [15:0]              checksum_o
`endif
);

    localparam int unsigned NumPix = WIDTH * HEIGHT;
    localparam int unsigned DataW  = 3 * PIXEL_DEPTH;
    localparam int unsigned EntryW = INDEX_WIDTH + DataW;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

    state_t                 state_q;
    logic [INDEX_WIDTH-1:0] addr_q;
    logic [12:0]            row_q;
    logic [12:0]            col_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   overflow_q;

    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   last_pix;
    logic                   drained;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CntW-1:0]        fifo_count;
    logic [EntryW-1:0]      fifo_head;

    assign accept   = (state_q == StCapture) && valid_i;
    assign push     = accept && !fifo_full;
    assign pop      = !fifo_empty && mem.mem_wr_ready;
    assign last_pix = (addr_q == INDEX_WIDTH'(NumPix - 1));
    // Leave DRAIN as the final entry is written, so frame_done follows the last write directly.
    assign drained  = fifo_empty || ((fifo_count == CntW'(1)) && pop);

    pixel_wr_fifo #(
        .DATA_WIDTH(EntryW),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data({addr_q, pix_i}),
        .pop      (pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign mem.mem_wr_en   = !fifo_empty;
    assign mem.mem_wr_addr = fifo_head[EntryW-1:DataW];
    assign mem.mem_wr_data = fifo_head[DataW-1:0];

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overflow   = overflow_q;
    assign row_o      = row_q;
    assign col_o      = col_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StCapture;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                    end
                end
                StCapture: begin
                    if (accept) begin
                        // Dropped pixels still consume their slot in the frame.
                        if (fifo_full) begin
                            overflow_q <= 1'b1;
                        end
                        if (last_pix) begin
                            state_q <= StDrain;
                            addr_q  <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else begin
                            addr_q <= addr_q + INDEX_WIDTH'(1);
                            if (col_q == 13'(WIDTH - 1)) begin
                                col_q <= '0;
                                row_q <= row_q + 13'd1;
                            end else begin
                                col_q <= col_q + 13'd1;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef PIXEL_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q
                        + 16'(pix_i[3*PIXEL_DEPTH-1:2*PIXEL_DEPTH])
                        + 16'(pix_i[2*PIXEL_DEPTH-1:PIXEL_DEPTH])
                        + 16'(pix_i[PIXEL_DEPTH-1:0]);
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer on a 4x2 frame with a frame-level reference model.
module tb_pixel_frame_writer;
    import pixel_stream_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned FD   = 4;
    localparam int unsigned IW   = 19;
    localparam int unsigned PD   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        valid_i;
    logic [23:0] pix_i;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [12:0] row_o;
    logic [12:0] col_o;
`ifdef PIXEL_CHECKSUM_EN
    logic [15:0] checksum_o;
`endif

    pixel_frame_writer_if #(.INDEX_WIDTH(IW), .PIXEL_DEPTH(PD)) mem_bus ();

    pixel_frame_writer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .PIXEL_DEPTH(PD),
        .INDEX_WIDTH(IW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .valid_i   (valid_i),
        .pix_i     (pix_i),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow),
        .row_o     (row_o),
        .col_o     (col_o),
        .mem       (mem_bus)
`ifdef PIXEL_CHECKSUM_EN
        ,
        .checksum_o(checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is active from start until its queue has emptied;
    // m_n counts strobes taken, so position is plain division of m_n by W.
    bit          m_active = 0;
    bit          m_done   = 0;
    bit          m_ovf    = 0;
    int          m_n      = 0;
    int          m_sum    = 0;
    int          m_q_addr[$];
    logic [23:0] m_q_data[$];
    bit          m_pop;
    bit          m_full;
    bit          m_fin;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_active = 0;
            m_done   = 0;
            m_ovf    = 0;
            m_n      = 0;
            m_sum    = 0;
            m_q_addr.delete();
            m_q_data.delete();
        end else begin
            m_pop  = (m_q_addr.size() > 0) && mem_bus.mem_wr_ready;
            m_full = (m_q_addr.size() == FD);
            m_fin  = 0;
            if (!m_done) begin
                if (!m_active) begin
                    if (start) begin
                        m_active = 1;
                        m_n      = 0;
                        m_ovf    = 0;
                        m_sum    = 0;
                    end
                end else if (m_n < NPIX) begin
                    if (valid_i) begin
                        if (m_full) begin
                            m_ovf = 1;
                        end else begin
                            m_q_addr.push_back(m_n);
                            m_q_data.push_back(pix_i);
                        end
                        m_sum = (m_sum + int'(pix_i[23:16]) + int'(pix_i[15:8])
                                 + int'(pix_i[7:0])) & 32'hFFFF;
                        m_n++;
                    end
                end else if (m_q_addr.size() == 0 || (m_q_addr.size() == 1 && m_pop)) begin
                    m_active = 0;
                    m_fin    = 1;
                end
            end
            if (m_pop) begin
                void'(m_q_addr.pop_front());
                void'(m_q_data.pop_front());
            end
            m_done = m_fin;
        end
    end

    // Observed write log and frame-completion snapshots.
    int          wr_addr_log[$];
    logic [23:0] wr_data_log[$];
    int          last_wr_cyc = 0;
    int          done_cyc    = 0;
    int          done_ovf    = 0;
    int          done_sum    = 0;
    bit          stall_prev  = 0;
    int          prev_addr   = 0;
    int          prev_data   = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", busy, m_active);
            check("frame_done", frame_done, m_done);
            check("overflow", overflow, m_ovf);
            check("row_o", row_o, (m_n % NPIX) / W);
            check("col_o", col_o, m_n % W);
            check("mem_wr_en", mem_bus.mem_wr_en, m_q_addr.size() > 0);
            if (mem_bus.mem_wr_en && m_q_addr.size() > 0) begin
                check("mem_wr_addr", mem_bus.mem_wr_addr, m_q_addr[0]);
                check("mem_wr_data", mem_bus.mem_wr_data, m_q_data[0]);
            end
`ifdef PIXEL_CHECKSUM_EN
            check("checksum_o", checksum_o, m_sum);
`endif
        end
        if (stall_prev && mem_bus.mem_wr_en) begin
            check("stall_addr_hold", mem_bus.mem_wr_addr, prev_addr);
            check("stall_data_hold", mem_bus.mem_wr_data, prev_data);
        end
        stall_prev = mem_bus.mem_wr_en && !mem_bus.mem_wr_ready;
        prev_addr  = mem_bus.mem_wr_addr;
        prev_data  = mem_bus.mem_wr_data;
        if (mem_bus.mem_wr_en && mem_bus.mem_wr_ready) begin
            wr_addr_log.push_back(mem_bus.mem_wr_addr);
            wr_data_log.push_back(mem_bus.mem_wr_data);
            last_wr_cyc = cyc;
        end
        if (frame_done) begin
            done_cyc = cyc;
            done_ovf = overflow;
`ifdef PIXEL_CHECKSUM_EN
            done_sum = checksum_o;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] p);
        valid_i = 1'b1;
        pix_i   = p;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int i = 0;
        while (frame_done !== 1'b1 && i < budget) begin
            if (toggle) mem_bus.mem_wr_ready = ~mem_bus.mem_wr_ready;
            tick();
            i++;
        end
        check("frame_done_within_budget", frame_done, 1);
        tick();
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    function automatic logic [23:0] kpix(input int k);
        return 24'(32'h010101 * k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pixel_t p80;
        reset_n              = 1'b0;
        start                = 1'b0;
        valid_i              = 1'b0;
        pix_i                = '0;
        mem_bus.mem_wr_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_wr_en", mem_bus.mem_wr_en, 0);
        check("rst_row", row_o, 0);
        check("rst_col", col_o, 0);
        reset_n = 1'b1;
        tick();

        // Back-to-back frame with the buffer always ready.
        clear_logs();
        mem_bus.mem_wr_ready = 1'b1;
        do_start();
        for (int k = 0; k < 8; k++) strobe(kpix(k));
        wait_done(50, 0);
        check("t1_nwrites", wr_addr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
            check("t1_addr", wr_addr_log[i], i);
            check("t1_data", wr_data_log[i], kpix(i));
        end
        check("t1_done_after_last_write", done_cyc - last_wr_cyc, 1);
        check("t1_ovf", done_ovf, 0);

        // Buffer stalled: the queue fills and pixels 4 and 5 are dropped.
        clear_logs();
        mem_bus.mem_wr_ready = 1'b0;
        do_start();
        for (int k = 0; k < 6; k++) strobe(24'h100000 + 24'(k));
        check("t2_ovf", overflow, 1);
        check("t2_row", row_o, 1);
        check("t2_col", col_o, 2);
        check("t2_wr_en", mem_bus.mem_wr_en, 1);
        check("t2_head_addr", mem_bus.mem_wr_addr, 0);
        check("t2_head_data", mem_bus.mem_wr_data, 24'h100000);
        mem_bus.mem_wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        strobe(24'h100006);
        strobe(24'h100007);
        wait_done(50, 0);
        check("t2_nwrites", wr_addr_log.size(), 6);
        if (wr_addr_log.size() == 6) begin
            check("t2_a0", wr_addr_log[0], 0);
            check("t2_a3", wr_addr_log[3], 3);
            check("t2_a4", wr_addr_log[4], 6);
            check("t2_a5", wr_addr_log[5], 7);
            check("t2_d4", wr_data_log[4], 24'h100006);
        end
        check("t2_ovf_sticky", overflow, 1);

        // Strobes in idle and a repeated start mid-capture are ignored.
        clear_logs();
        for (int k = 0; k < 3; k++) strobe(24'hABCDEF);
        check("t3_idle_writes", wr_addr_log.size(), 0);
        check("t3_idle_col", col_o, 0);
        do_start();
        check("t3_ovf_cleared", overflow, 0);
        strobe(kpix(0));
        strobe(kpix(1));
        do_start();
        check("t3_col_after_restart", col_o, 2);
        check("t3_row_after_restart", row_o, 0);
        for (int k = 2; k < 8; k++) strobe(kpix(k));
        wait_done(50, 0);
        check("t3_nwrites", wr_addr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
            check("t3_addr", wr_addr_log[i], i);
        end

        // Ready alternating 1,0,... from the first strobe: only pixel 6 finds the queue full.
        clear_logs();
        do_start();
        for (int c = 0; c < 8; c++) begin
            mem_bus.mem_wr_ready = (c % 2 == 0);
            strobe(kpix(c + 8));
        end
        wait_done(50, 1);
        check("t4_nwrites", wr_addr_log.size(), 7);
        if (wr_addr_log.size() == 7) begin
            check("t4_a5", wr_addr_log[5], 5);
            check("t4_a6", wr_addr_log[6], 7);
            check("t4_d6", wr_data_log[6], kpix(15));
        end
        check("t4_ovf", done_ovf, 1);

        // Reset mid-frame discards the queue; the next frame restarts at address 0.
        mem_bus.mem_wr_ready = 1'b0;
        do_start();
        for (int k = 0; k < 3; k++) strobe(kpix(k));
        reset_n = 1'b0;
        tick();
        check("t5_busy", busy, 0);
        check("t5_done", frame_done, 0);
        check("t5_ovf", overflow, 0);
        check("t5_wr_en", mem_bus.mem_wr_en, 0);
        check("t5_row", row_o, 0);
        check("t5_col", col_o, 0);
        reset_n = 1'b1;
        clear_logs();
        mem_bus.mem_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t5_no_writes", wr_addr_log.size(), 0);
        do_start();
        for (int k = 0; k < 8; k++) strobe(kpix(k + 3));
        wait_done(50, 0);
        check("t5_nwrites", wr_addr_log.size(), 8);
        if (wr_addr_log.size() == 8) begin
            check("t5_a0", wr_addr_log[0], 0);
            check("t5_d0", wr_data_log[0], kpix(3));
            check("t5_a7", wr_addr_log[7], 7);
        end

`ifdef PIXEL_CHECKSUM_EN
        // Eight grey pixels of 0x80: 8 * 0x180 = 0x0C00.
        p80.r = 8'h80;
        p80.g = 8'h80;
        p80.b = 8'h80;
        do_start();
        for (int k = 0; k < 8; k++) strobe(p80);
        wait_done(50, 0);
        check("t6_checksum", done_sum, 16'h0C00);
        check("t6_checksum_hold", checksum_o, 16'h0C00);
`else
        p80 = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter PIXEL_DEPTH, default 8, bits per colour channel.
REQ-004 Parameter INDEX_WIDTH, default 19, frame-buffer address width.
REQ-005 Parameter FIFO_DEPTH, default 4, write-queue entries (power of two).
REQ-006 clk  input  1  clock, all logic rising-edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 start  input  1  arms capture of one frame.
REQ-009 valid_i  input  1  pixel strobe from upstream filter.
REQ-010 pix_i  input  3*PIXEL_DEPTH  {R,G,B} pixel.
REQ-011 mem_wr_en  output  1  write request to frame buffer.
REQ-012 mem_wr_addr  output  INDEX_WIDTH  linear address row*WIDTH+col.
REQ-013 mem_wr_data  output  3*PIXEL_DEPTH  pixel to write.
REQ-014 mem_wr_ready  input  1  frame buffer accepts write this cycle.
REQ-015 busy  output  1  high in CAPTURE or DRAIN.
REQ-016 frame_done  output  1  one-cycle pulse on frame completion.
REQ-017 overflow  output  1  sticky, a pixel was dropped this frame.
REQ-018 row_o, col_o  output  13 each  coordinate of next pixel to be accepted.

Function
REQ-019 States IDLE, CAPTURE, DRAIN, DONE; IDLE->CAPTURE on start; CAPTURE->DRAIN the cycle after the WIDTH*HEIGHT-th strobe; DRAIN->DONE when queue empty; DONE->IDLE unconditionally after one cycle.
REQ-020 frame_done SHALL be high exactly in DONE.
REQ-021 valid_i in IDLE, DRAIN, DONE SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-022 Each valid_i in CAPTURE advances col_o; col_o wraps WIDTH-1->0 incrementing row_o; after last pixel row_o,col_o return to 0.
REQ-023 Address SHALL be a linear counter incremented per strobe, no multiplier; equals row_o*WIDTH+col_o at acceptance.
REQ-024 Accepted pixel pushes {addr,pix_i} into queue, visible at outputs no earlier than next cycle.
REQ-025 Queue full (registered count==FIFO_DEPTH, no same-cycle pop bypass) with valid_i: pixel dropped, counters still advance, overflow set.
REQ-026 mem_wr_en = queue non-empty; pop when mem_wr_en && mem_wr_ready; mem_wr_addr/data SHALL hold stable while mem_wr_en && !mem_wr_ready.
REQ-027 Simultaneous push and pop with count<FIFO_DEPTH: count unchanged, order preserved.
REQ-028 overflow cleared on the IDLE->CAPTURE transition only.

Reset
REQ-029 reset_n low: state IDLE, queue empty, mem_wr_en, busy, frame_done, overflow, row_o, col_o, address counter all 0.
REQ-030 Reset mid-frame SHALL discard queued pixels; no further writes until next start.

Configuration
REQ-031 With PIXEL_CHECKSUM_EN defined: output checksum_o[15:0], modulo-2^16 sum of R+G+B of all accepted (including dropped) pixels of the frame, cleared on start, stable from DONE until next start.
REQ-032 Without PIXEL_CHECKSUM_EN: no checksum_o port, no checksum logic.

Structure
REQ-033 Package pixel_stream_pkg SHALL hold the state enum, the pixel struct {r,g,b} and the default WIDTH/HEIGHT/INDEX_WIDTH constants.
REQ-034 Queue SHALL be sub-module pixel_wr_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4 unless stated)
REQ-035 start, 8 back-to-back strobes pix=0x010101*k, mem_wr_ready=1 -> writes addr 0..7 data in order, frame_done one cycle after last write, overflow=0.
REQ-036 mem_wr_ready=0 throughout, 6 strobes -> pixels 4,5 dropped, overflow=1, counters reach row 1 col 2, queue holds addr 0..3.
REQ-037 strobes while IDLE, and second start during CAPTURE -> no writes, no counter change, capture unaffected.
REQ-038 mem_wr_ready toggling 1010..., strobe every cycle for full frame -> no loss with FIFO_DEPTH 4 only if drain keeps up; check addr/data stable during stalls and drop accounting exact.
REQ-039 reset_n low after 3 strobes -> all outputs 0 next cycle, subsequent start writes from addr 0.
REQ-040 PIXEL_CHECKSUM_EN, 8 pixels each R=G=B=0x80 -> checksum_o=0x0C00 at frame_done.
